mmio_bus_decoder: RTL
=====================

// Module: mmio_bus_decoder
// PURPOSE
//  Parametrised memory-mapped I/O decoder with a bus handshake, for the multicycle MIPS.
//  Decodes the CPU data address into N peripheral regions (GPIO, UART, ...).
//  Drives a one-hot slave select and waits for the addressed slave's ready.
//  Returns registered read data plus ack/err to the CPU. Sits between the datapath and the peripherals.
// PARAMETERS
//  ADDR_WIDTH     32     CPU address width
//  DATA_WIDTH     32     data bus width
//  NUM_SLAVES     2      number of decoded regions (0=GPIO, 1=UART)
//  REGION_BITS    8      low address bits inside a region (region = 2^REGION_BITS bytes)
//  BASE_ADDRS     {32'h1001_0100,32'h1001_0000}  packed NUM_SLAVES*ADDR_WIDTH; slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  TIMEOUT_CYCLES 16     max ACCESS cycles before bus error (MMIO_TIMEOUT_EN only)
// PORTS
//  clk        in   1                       clock; all logic on rising edge
//  reset      in   1                       synchronous reset, active-low
//  cpu_req    in   1                       access request, sampled only in IDLE
//  cpu_we     in   1                       1=write, 0=read
//  cpu_addr   in   ADDR_WIDTH              byte address
//  cpu_wdata  in   DATA_WIDTH              write data
//  cpu_rdata  out  DATA_WIDTH              read data, valid when cpu_ack=1
//  cpu_ack    out  1                       one-cycle completion pulse
//  cpu_err    out  1                       with cpu_ack: unmapped address or timeout
//  busy       out  1                       1 in any state other than IDLE
//  slv_sel    out  NUM_SLAVES              one-hot slave enable, held during ACCESS
//  slv_we     out  1                       registered cpu_we, valid while slv_sel!=0
//  slv_addr   out  REGION_BITS             registered cpu_addr[REGION_BITS-1:0]
//  slv_wdata  out  DATA_WIDTH              registered cpu_wdata
//  slv_rdata  in   NUM_SLAVES*DATA_WIDTH   packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//  slv_ready  in   NUM_SLAVES              per-slave completion
// BEHAVIOUR
//  - Hit i: cpu_addr[ADDR_WIDTH-1:REGION_BITS] == BASE_i[ADDR_WIDTH-1:REGION_BITS].
//    On overlapping regions the lowest index wins.
//  - FSM IDLE/ACCESS/ERROR/DONE:
//    * IDLE: cpu_req=1 registers we/addr/wdata and the hit index.
//      On a hit go to ACCESS; with no hit go to ERROR.
//    * ACCESS: slv_sel = one-hot of the hit index. Only slv_ready[idx] is honoured; other ready bits are ignored.
//      On ready: latch slv_rdata[idx] on a read, 0 on a write; go to DONE.
//    * ERROR: go to DONE with err pending and rdata=0. No slv_sel is asserted.
//    * DONE: cpu_ack=1 and cpu_err=pending for exactly one cycle, then IDLE.
//  - Latency: req at edge N; ACCESS from N+1; ready in the first ACCESS cycle gives ack at N+2 (2-cycle minimum).
//    Unmapped address: ack+err at N+2.
//  - cpu_req outside IDLE is ignored; a req held high through DONE starts a new access in the next IDLE cycle.
//  - cpu_rdata holds its value until the next ack. slv_sel is 0 outside ACCESS.
//  - Reset (reset=0 at an edge): state=IDLE. All outputs 0 (cpu_rdata, cpu_ack, cpu_err, busy, slv_*).
//    Reset mid-ACCESS drops slv_sel at that edge; no ack is issued for the aborted access.
// CONFIGURATION
//  MMIO_TIMEOUT_EN defined:
//    - Counter cleared on entry to ACCESS, +1 per ACCESS cycle.
//    - When TIMEOUT_CYCLES cycles elapse with no ready: DONE with err=1 and rdata=0.
//    - Ready in the same cycle as the timeout wins: normal completion.
//  MMIO_TIMEOUT_EN undefined: no counter; ACCESS waits for ready indefinitely.
// TESTING
//  1. Read GPIO 0x1001_0004, slv_ready[0]=1 at once, slv_rdata[0]=32'hCAFE_0001
//     -> slv_sel=2'b01, slv_addr=8'h04, ack at req+2, rdata=CAFE_0001, err=0.
//  2. Write UART 0x1001_0100 data 32'h41, ready after 3 cycles
//     -> slv_sel=2'b10 for 3 cycles, slv_we=1, slv_wdata=32'h41, ack with rdata=0, err=0.
//  3. Read 0x2000_0000 (unmapped) -> slv_sel stays 0, ack+err at req+2, rdata=0.
//  4. Back-to-back: req held high across two reads -> second ACCESS starts the cycle after DONE;
//     cpu_req is ignored while busy=1.
//  5. reset=0 during ACCESS -> next edge: slv_sel=0, busy=0, no ack; a following read completes normally.
//  6. MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=16, ready never asserted -> ack+err after 16 ACCESS cycles, rdata=0.
//     Build without the macro -> busy stays 1 indefinitely.

Source files
------------

// File: rtl/mmio_bus_decoder.sv
// MMIO address decoder with a select/ready bus handshake to N peripheral regions.
// Optional access watchdog enabled by defining MMIO_TIMEOUT_EN.
module mmio_bus_decoder #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 2,
  parameter int unsigned REGION_BITS    = 8,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = {32'h1001_0100, 32'h1001_0000},
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             cpu_ack,
  output logic                             cpu_err,
  output logic                             busy,
  output logic [NUM_SLAVES-1:0]            slv_sel,
  output logic                             slv_we,
  output logic [REGION_BITS-1:0]           slv_addr,
  output logic [DATA_WIDTH-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]            slv_ready
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || TIMEOUT_CYCLES < 1 || REGION_BITS >= ADDR_WIDTH) begin : gBadParams
    $error("mmio_bus_decoder: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERROR,
    DONE
  } stateT;

  stateT                  state;
  logic [IDX_W-1:0]       idx;

  logic                   hitValid;
  logic [IDX_W-1:0]       hitIdx;
  logic [NUM_SLAVES-1:0]  hitOneHot;
  logic                   selReady;
  logic [DATA_WIDTH-1:0]  selRdata;
  logic                   timedOut;

  // First matching region in index order wins when regions overlap.
  always_comb begin
    hitValid  = 1'b0;
    hitIdx    = '0;
    hitOneHot = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hitValid &&
          cpu_addr[ADDR_WIDTH-1:REGION_BITS] ==
          BASE_ADDRS[i*ADDR_WIDTH+REGION_BITS +: ADDR_WIDTH-REGION_BITS]) begin
        hitValid     = 1'b1;
        hitIdx       = IDX_W'(i);
        hitOneHot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    selReady = 1'b0;
    selRdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IDX_W'(i)) begin
        selReady = slv_ready[i];
        selRdata = slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] accCnt;

  // Held at zero outside ACCESS, so every access starts counting from zero.
  always_ff @(posedge clk) begin
    if (!reset || state != ACCESS) begin
      accCnt <= '0;
    end else begin
      accCnt <= accCnt + TMR_W'(1);
    end
  end

  assign timedOut = (accCnt == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign timedOut = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      busy      <= 1'b0;
      slv_sel   <= '0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            slv_we    <= cpu_we;
            slv_addr  <= cpu_addr[REGION_BITS-1:0];
            slv_wdata <= cpu_wdata;
            idx       <= hitIdx;
            busy      <= 1'b1;
            if (hitValid) begin
              slv_sel <= hitOneHot;
              state   <= ACCESS;
            end else begin
              state   <= ERROR;
            end
          end
        end
        ACCESS: begin
          // Ready is checked before the watchdog so a last-cycle ready still completes.
          if (selReady) begin
            cpu_rdata <= slv_we ? '0 : selRdata;
            cpu_ack   <= 1'b1;
            slv_sel   <= '0;
            state     <= DONE;
          end else if (timedOut) begin
            cpu_rdata <= '0;
            cpu_ack   <= 1'b1;
            cpu_err   <= 1'b1;
            slv_sel   <= '0;
            state     <= DONE;
          end
        end
        ERROR: begin
          cpu_rdata <= '0;
          cpu_ack   <= 1'b1;
          cpu_err   <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
